// File: rtl/alu_s_if.sv
// rtl/alu_s_if.sv - Handshake, operand and status bundle for the sequenced ALU alu_s
//
// Purpose : groups the control handshake (start/op/busy/done), the operands
//           (w_in, bus_in, carry_in) and the registered result/flag outputs
//           with their status-register write strobes.
// Modports: master - the sequencer/testbench side driving requests
//           slave  - the ALU side (alu_s)
// The tri-state shared-bus driver data_out is a plain port of alu_s, because
// it has to resolve as a net with other bus drivers.

interface alu_s_if;
    logic       start;
    logic [3:0] op;
    logic [7:0] w_in;
    logic [7:0] bus_in;
    logic       carry_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       zero_out;
    logic       carry_wr;
    logic       zero_wr;

    modport master (
        output start, op, w_in, bus_in, carry_in,
        input  busy, done, result, carry_out, zero_out, carry_wr, zero_wr
    );

    modport slave (
        input  start, op, w_in, bus_in, carry_in,
        output busy, done, result, carry_out, zero_out, carry_wr, zero_wr
    );
endinterface

// File: rtl/alu_s.sv
// rtl/alu_s.sv - Sequenced 8-bit ALU (IDLE/FETCH/EXEC/WRITE) for the PIC datapath
//
// Purpose : one operation per accepted start. The opcode is latched in IDLE,
//           operands in FETCH, results/flags/strobe enables in EXEC, and the
//           result is driven on the shared bus with a done pulse in WRITE.
// Ports   : clock    - rising-edge clock
//           reset    - asynchronous active-low reset
//           s        - alu_s_if.slave: start, op, w_in, bus_in, carry_in in;
//                      busy, done, result, carry_out, zero_out, carry_wr,
//                      zero_wr out
//           data_out - shared bus driver, high-Z unless WRITE of a
//                      result-producing opcode
// Config  : ALU_ROTATE_EN - enables RLF (8) and RRF (9); when undefined both
//           behave as reserved opcodes and carry_in is ignored.
//
// Every output is decoded from registers only, so there is no combinational
// path from any input to any output.

module alu_s (
    input  logic     clock,
    input  logic     reset,
    alu_s_if.slave   s,
    output wire [7:0] data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_IOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_COM  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_RLF  = 4'd8;
    localparam logic [3:0] OP_RRF  = 4'd9;
    localparam logic [3:0] OP_SWAP = 4'd10;
    localparam logic [3:0] OP_CLR  = 4'd11;
    localparam logic [3:0] OP_MOVF = 4'd12;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] w_q, w_d;
    logic [7:0] f_q, f_d;
    logic [7:0] result_q, result_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    logic       cwr_en_q, cwr_en_d;   // op writes carry: strobe in WRITE
    logic       zwr_en_q, zwr_en_d;   // op writes zero: strobe in WRITE
    logic       drv_q, drv_d;         // op produces a result for the bus

`ifdef ALU_ROTATE_EN
    logic       c_q, c_d;             // carry_in snapshot taken in FETCH
`else
    logic       unused_carry_in;
    assign unused_carry_in = s.carry_in;
`endif

    // Per-opcode decode of the latched operands, consumed only in EXEC.
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_wr_c;
    logic       alu_wr_z;
    logic       alu_drv;

    assign sum9  = {1'b0, f_q} + {1'b0, w_q};
    // Two's-complement subtract; bit 8 set means no borrow.
    assign diff9 = {1'b0, f_q} + {1'b0, ~w_q} + 9'd1;

    always_comb begin
        alu_res  = result_q;
        alu_c    = carry_q;
        alu_wr_c = 1'b0;
        alu_wr_z = 1'b0;
        alu_drv  = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_res  = sum9[7:0];
                alu_c    = sum9[8];
                alu_wr_c = 1'b1;
                alu_wr_z = 1'b1;
            end
            OP_SUB: begin
                alu_res  = diff9[7:0];
                alu_c    = diff9[8];
                alu_wr_c = 1'b1;
                alu_wr_z = 1'b1;
            end
            OP_AND: begin
                alu_res  = f_q & w_q;
                alu_wr_z = 1'b1;
            end
            OP_IOR: begin
                alu_res  = f_q | w_q;
                alu_wr_z = 1'b1;
            end
            OP_XOR: begin
                alu_res  = f_q ^ w_q;
                alu_wr_z = 1'b1;
            end
            OP_COM: begin
                alu_res  = ~f_q;
                alu_wr_z = 1'b1;
            end
            OP_INC: begin
                alu_res  = f_q + 8'd1;
                alu_wr_z = 1'b1;
            end
            OP_DEC: begin
                alu_res  = f_q - 8'd1;
                alu_wr_z = 1'b1;
            end
`ifdef ALU_ROTATE_EN
            OP_RLF: begin
                alu_res  = {f_q[6:0], c_q};
                alu_c    = f_q[7];
                alu_wr_c = 1'b1;
            end
            OP_RRF: begin
                alu_res  = {c_q, f_q[7:1]};
                alu_c    = f_q[0];
                alu_wr_c = 1'b1;
            end
`endif
            OP_SWAP: begin
                alu_res  = {f_q[3:0], f_q[7:4]};
            end
            OP_CLR: begin
                alu_res  = 8'h00;
                alu_wr_z = 1'b1;
            end
            OP_MOVF: begin
                alu_res  = f_q;
                alu_wr_z = 1'b1;
            end
            default: begin
                // Reserved (and rotates when disabled): keep everything,
                // leave the bus undriven, still sequence through WRITE.
                alu_drv  = 1'b0;
            end
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        w_d      = w_q;
        f_d      = f_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        cwr_en_d = cwr_en_q;
        zwr_en_d = zwr_en_q;
        drv_d    = drv_q;
`ifdef ALU_ROTATE_EN
        c_d      = c_q;
`endif
        case (state_q)
            IDLE: begin
                if (s.start) begin
                    state_d = FETCH;
                    op_d    = s.op;
                end
            end
            FETCH: begin
                state_d = EXEC;
                w_d     = s.w_in;
                f_d     = s.bus_in;
`ifdef ALU_ROTATE_EN
                c_d     = s.carry_in;
`endif
            end
            EXEC: begin
                state_d  = WRITE;
                cwr_en_d = alu_wr_c;
                zwr_en_d = alu_wr_z;
                drv_d    = alu_drv;
                if (alu_drv) begin
                    result_d = alu_res;
                end
                if (alu_wr_c) begin
                    carry_d = alu_c;
                end
                if (alu_wr_z) begin
                    zero_d = (alu_res == 8'h00);
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= 4'd0;
            w_q      <= 8'h00;
            f_q      <= 8'h00;
            result_q <= 8'h00;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            cwr_en_q <= 1'b0;
            zwr_en_q <= 1'b0;
            drv_q    <= 1'b0;
`ifdef ALU_ROTATE_EN
            c_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            w_q      <= w_d;
            f_q      <= f_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            cwr_en_q <= cwr_en_d;
            zwr_en_q <= zwr_en_d;
            drv_q    <= drv_d;
`ifdef ALU_ROTATE_EN
            c_q      <= c_d;
`endif
        end
    end

    logic in_write;
    assign in_write = (state_q == WRITE);

    assign s.busy      = (state_q != IDLE);
    assign s.done      = in_write;
    assign s.carry_wr  = in_write & cwr_en_q;
    assign s.zero_wr   = in_write & zwr_en_q;
    assign s.result    = result_q;
    assign s.carry_out = carry_q;
    assign s.zero_out  = zero_q;

    assign data_out = (in_write && drv_q) ? result_q : 8'bz;

endmodule

// File: tb/tb_alu_s.sv
// tb/tb_alu_s.sv - Directed table-driven bench for alu_s

module tb_alu_s;

`ifdef ALU_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic      clock;
    logic      reset;
    wire [7:0] data_out;

    alu_s_if bus ();

    alu_s dut (
        .clock    (clock),
        .reset    (reset),
        .s        (bus.slave),
        .data_out (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] op;
        logic [7:0] w;
        logic [7:0] f;
        logic       c;
        logic [7:0] res;
        logic       cf;
        logic       zf;
        logic       cwr;
        logic       zwr;
        logic       drv;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic [7:0] w, input logic [7:0] f,
                       input logic c, input logic [7:0] res, input logic cf, input logic zf,
                       input logic cwr, input logic zwr, input logic drv);
        vec_t v;
        v.op = op; v.w = w; v.f = f; v.c = c; v.res = res;
        v.cf = cf; v.zf = zf; v.cwr = cwr; v.zwr = zwr; v.drv = drv;
        vecs.push_back(v);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after N+3 (IDLE again).
    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] zz;
        zz = 8'bz;
        bus.start    = 1'b1;
        bus.op       = v.op;
        bus.w_in     = v.w;
        bus.bus_in   = v.f;
        bus.carry_in = v.c;
        @(posedge clock);
        #1 bus.start = 1'b0;
        @(negedge clock);
        chk($sformatf("v%0d fetch busy", idx), 32'(bus.busy), 32'd1);
        @(negedge clock);
        chk($sformatf("v%0d exec done", idx), 32'(bus.done), 32'd0);
        chk($sformatf("v%0d exec strobes", idx), {30'd0, bus.carry_wr, bus.zero_wr}, 32'd0);
        @(negedge clock);
        chk($sformatf("v%0d write done", idx), 32'(bus.done), 32'd1);
        chk($sformatf("v%0d carry_wr", idx), 32'(bus.carry_wr), 32'(v.cwr));
        chk($sformatf("v%0d zero_wr", idx), 32'(bus.zero_wr), 32'(v.zwr));
        chk($sformatf("v%0d data_out", idx), {24'd0, data_out}, {24'd0, (v.drv ? v.res : zz)});
        @(negedge clock);
        chk($sformatf("v%0d idle done", idx), {30'd0, bus.busy, bus.done}, 32'd0);
        chk($sformatf("v%0d result", idx), {24'd0, bus.result}, {24'd0, v.res});
        chk($sformatf("v%0d carry_out", idx), 32'(bus.carry_out), 32'(v.cf));
        chk($sformatf("v%0d zero_out", idx), 32'(bus.zero_out), 32'(v.zf));
        chk($sformatf("v%0d idle data_out", idx), {24'd0, data_out}, {24'd0, zz});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] zz;
        logic       cx;
        int         dones;
        int         stray;
        vec_t       v;
        zz = 8'bz;
        cx = ROT ? 1'b0 : 1'b1;

        //   op     w      f      c     res                     cf    zf    cwr   zwr   drv
        add(4'd0,  8'hF0, 8'h10, 1'b0, 8'h00,                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        add(4'd1,  8'h05, 8'h03, 1'b0, 8'hFE,                  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        add(4'd1,  8'h03, 8'h03, 1'b0, 8'h00,                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        add(4'd2,  8'h0F, 8'h3C, 1'b0, 8'h0C,                  1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        add(4'd3,  8'h00, 8'h00, 1'b0, 8'h00,                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        add(4'd4,  8'hAA, 8'h55, 1'b0, 8'hFF,                  1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        add(4'd5,  8'h00, 8'hFF, 1'b0, 8'h00,                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        add(4'd7,  8'h00, 8'h00, 1'b0, 8'hFF,                  1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        add(4'd0,  8'hFF, 8'h02, 1'b0, 8'h01,                  1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        add(4'd6,  8'h00, 8'hFF, 1'b0, 8'h00,                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        add(4'd10, 8'h00, 8'hA5, 1'b0, 8'h5A,                  1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(4'd8,  8'h00, 8'h81, 1'b0, ROT ? 8'h02 : 8'h5A,    1'b1, 1'b1, ROT,  1'b0, ROT);
        add(4'd9,  8'h00, 8'h02, 1'b1, ROT ? 8'h81 : 8'h5A,    cx,   1'b1, ROT,  1'b0, ROT);
        add(4'd12, 8'h00, 8'h00, 1'b0, 8'h00,                  cx,   1'b1, 1'b0, 1'b1, 1'b1);
        add(4'd11, 8'h77, 8'h99, 1'b0, 8'h00,                  cx,   1'b1, 1'b0, 1'b1, 1'b1);
        add(4'd12, 8'h00, 8'h7E, 1'b0, 8'h7E,                  cx,   1'b0, 1'b0, 1'b1, 1'b1);
        add(4'd14, 8'h12, 8'h33, 1'b1, 8'h7E,                  cx,   1'b0, 1'b0, 1'b0, 1'b0);
        add(4'd13, 8'h00, 8'h00, 1'b1, 8'h7E,                  cx,   1'b0, 1'b0, 1'b0, 1'b0);
        add(4'd15, 8'hFF, 8'hFF, 1'b0, 8'h7E,                  cx,   1'b0, 1'b0, 1'b0, 1'b0);

        bus.start    = 1'b0;
        bus.op       = 4'd0;
        bus.w_in     = 8'h00;
        bus.bus_in   = 8'h00;
        bus.carry_in = 1'b0;
        reset        = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("reset result", {24'd0, bus.result}, 32'd0);
        chk("reset flags", {30'd0, bus.carry_out, bus.zero_out}, 32'd0);
        chk("reset strobes", {30'd0, bus.carry_wr, bus.zero_wr}, 32'd0);
        chk("reset data_out", {24'd0, data_out}, {24'd0, zz});
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // start held high through FETCH and EXEC must not queue a second op.
        bus.start  = 1'b1;
        bus.op     = 4'd0;
        bus.w_in   = 8'h01;
        bus.bus_in = 8'h01;
        dones = 0;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1 bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus.done) dones++;
        end
        chk("held start done count", 32'(dones), 32'd1);
        chk("held start result", {24'd0, bus.result}, 32'h02);

        // Reset during EXEC of ADD aborts the op immediately.
        bus.start  = 1'b1;
        bus.op     = 4'd0;
        bus.w_in   = 8'hF0;
        bus.bus_in = 8'h10;
        @(posedge clock);
        #1 bus.start = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("abort busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("abort result", {24'd0, bus.result}, 32'd0);
        chk("abort flags", {30'd0, bus.carry_out, bus.zero_out}, 32'd0);
        chk("abort strobes", {30'd0, bus.carry_wr, bus.zero_wr}, 32'd0);
        chk("abort data_out", {24'd0, data_out}, {24'd0, zz});
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (bus.done || bus.carry_wr || bus.zero_wr || bus.busy) stray++;
        end
        chk("no resume after abort", 32'(stray), 32'd0);

        // Fresh ADD after the abort completes normally from reset state.
        v.op = 4'd0; v.w = 8'hF0; v.f = 8'h10; v.c = 1'b0; v.res = 8'h00;
        v.cf = 1'b1; v.zf = 1'b1; v.cwr = 1'b1; v.zwr = 1'b1; v.drv = 1'b1;
        run_vec(99, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
